dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: port 0 = core load/store unit, port 1 = debug/DMA loader.
- Arbitrates round-robin and decodes RISC-V funct3 plus address into byte-lane selects and load select.
- Checks alignment and address range, sequences the access, and returns a one-cycle response pulse per transaction.
- Sits between the LSU/debug logic and the dataMemory instance.

Parameters:
BASE_ADDR, 32'h80000000, first byte address of data memory
DEPTH_WORDS, 1024, memory depth in 32-bit words; valid range is [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
READ_LAT, 1, cycles from the memReadEnable cycle to valid memDataOut (legal 1..3)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
reqValid  in  2  per-port request; held stable until reqGnt seen
reqWrite  in  2  per-port 1=store, 0=load
reqFunct3  in  6  port p at [3p+2:3p]; 000 B, 001 H, 010 W, 100 BU, 101 HU
reqAddr  in  64  port p at [32p+31:32p], byte address
reqWdata  in  64  port p at [32p+31:32p], store data LSB-aligned
reqGnt  out  2  one-hot, one-cycle grant pulse
rspValid  out  2  one-hot, one-cycle response pulse
rspErr  out  1  qualifies rspValid: misaligned or out of range, no memory access made
rspData  out  32  load result, valid with rspValid; 0 for stores and errors
memReadEnable  out  1  to dataMemory readEnable
memWriteEnable  out  1  to dataMemory writeEnable
memWriteByteSelect  out  4  byte lanes written
memReadByteSelect  out  4  byte lanes read
memLoadSelect  out  3  latched funct3
memAddress  out  32  full byte address (memory subtracts base)
memDataIn  out  32  store data shifted to its byte lanes
memDataOut  in  32  read data from memory

Behaviour:
- Reset: async on rst_n low; in-flight access is dropped. All outputs are 0, state IDLE, lastGrant=1 so port 0 wins the first tie. All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, ERRRSP.
- IDLE: arbitration happens only here.
  - Single requester: it wins.
  - Both requesting: the port != lastGrant wins.
  - At edge E0 the winner's command and id are latched, lastGrant is updated, and reqGnt[id]=1 for the E0–E1 cycle.
  - A reqValid still high in a later IDLE cycle is a new request.
- Decode uses off=addr[1:0].
  - B/BU: byteSel=0001<<off.
  - H/HU: byteSel=0011<<off; off must be 0 or 2.
  - W: byteSel=1111; off must be 0.
  - Store data: memDataIn = wdata<<(8*off).
  - Error when: alignment is violated; funct3 is illegal (011, 110, 111, or 1xx on a store); or address is out of range.
- Error path: IDLE→ERRRSP. No mem enables are asserted. rspValid[id]=1 and rspErr=1 during E1–E2, then IDLE.
- Normal path: IDLE→ACCESS.
  - During E0–E1: mem enable, byte select, address, memLoadSelect and memDataIn are driven.
  - Store: memWriteEnable=1 and memWriteByteSelect=byteSel. At E1 the write commits, rspValid[id]=1 during E1–E2, and the FSM returns to IDLE.
  - Load: memReadEnable=1 and memReadByteSelect=byteSel. At E1 the FSM goes to WAIT and loads a counter with READ_LAT.
- WAIT: the counter decrements each edge. At the edge where it reaches 0, rspData is captured from memDataOut unmodified, rspValid[id]=1 for one cycle, and the FSM returns to IDLE.
- Latency from E0 to the response cycle: store 1 edge; load 1+READ_LAT edges; error 1 edge.
- Back-to-back throughput: next arbitration at the edge after the response edge, so a store takes 2 cycles per access.
- Mem enables are high only in ACCESS. Address, data and selects hold their last values otherwise.
- reqGnt and rspValid are never both high for different ports in the same cycle unless a grant coincides with an old response, which cannot happen because arbitration waits for IDLE.
- Address check arithmetic is 33-bit so the top of the range does not wrap.

Test Plan:
1. Port 0 SW addr 80000004 data A5A5A5A5 → reqGnt=01 after E0; memWriteEnable=1 and sel 1111 for one cycle; rspValid=01, rspErr=0 after E1. Then LW same addr → rspValid after E2 (READ_LAT=1), rspData=A5A5A5A5.
2. Port 1 SH addr 8000000A data 0000BEEF → memWriteByteSelect=1100, memDataIn=BEEF0000. Then LHU 8000000A → memReadByteSelect=1100, memLoadSelect=101.
3. Both ports request continuously from reset → grants 01,10,01,10; no port waits more than one transaction.
4. Port 0 LW 80000002 → rspErr=1 after E1, no mem enables, rspData=0. Port 0 LB 7FFFFFFF and SW 80001000 (DEPTH_WORDS=1024) → rspErr=1.
5. READ_LAT=3: LW → rspValid exactly 4 edges after grant edge; memReadEnable high one cycle only.
6. rst_n low during WAIT → all outputs 0 immediately; no rspValid after release; the next request is granted to port 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin front end for the data memory: decodes RISC-V funct3 and
// address into byte lanes, rejects misaligned/out-of-range accesses, sequences access.
module dmem_arbiter #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned READ_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  reqValid,
   input  logic [1:0]  reqWrite,
   input  logic [5:0]  reqFunct3,
   input  logic [63:0] reqAddr,
   input  logic [63:0] reqWdata,
   output logic [1:0]  reqGnt,
   output logic [1:0]  rspValid,
   output logic        rspErr,
   output logic [31:0] rspData,
   output logic        memReadEnable,
   output logic        memWriteEnable,
   output logic [3:0]  memWriteByteSelect,
   output logic [3:0]  memReadByteSelect,
   output logic [2:0]  memLoadSelect,
   output logic [31:0] memAddress,
   output logic [31:0] memDataIn,
   input  logic [31:0] memDataOut
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_ERRRSP = 2'd3;

   // 33-bit bounds so a memory ending at 2^32 does not wrap to zero
   localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] ADDR_HI = ADDR_LO + (33'(DEPTH_WORDS) << 2);
   localparam logic [1:0]  LAT     = 2'(READ_LAT);

   logic [1:0]  state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        id_q, id_d;
   logic        write_q, write_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        mem_re_q, mem_re_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_wsel_q, mem_wsel_d;
   logic [3:0]  mem_rsel_q, mem_rsel_d;
   logic [2:0]  mem_lsel_q, mem_lsel_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_din_q, mem_din_d;

   logic        win_id;
   logic        sel_write;
   logic [2:0]  sel_f3;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  off;
   logic [32:0] addr33;
   logic [3:0]  dec_sel;
   logic        dec_err;
   logic        in_range;

   always_comb begin
      win_id    = (reqValid[0] && reqValid[1]) ? ~last_grant_q : reqValid[1];
      sel_write = win_id ? reqWrite[1]       : reqWrite[0];
      sel_f3    = win_id ? reqFunct3[5:3]    : reqFunct3[2:0];
      sel_addr  = win_id ? reqAddr[63:32]    : reqAddr[31:0];
      sel_wdata = win_id ? reqWdata[63:32]   : reqWdata[31:0];
      off       = sel_addr[1:0];
      addr33    = {1'b0, sel_addr};
      in_range  = (addr33 >= ADDR_LO) && (addr33 < ADDR_HI);

      dec_sel = 4'b0000;
      dec_err = 1'b0;
      case (sel_f3[1:0])
         2'b00: dec_sel = 4'b0001 << off;
         2'b01: begin
            dec_sel = 4'b0011 << off;
            dec_err = off[0];
         end
         2'b10: begin
            dec_sel = 4'b1111;
            dec_err = (off != 2'b00) || sel_f3[2];
         end
         default: dec_err = 1'b1;
      endcase
      if ((sel_write && sel_f3[2]) || !in_range) begin
         dec_err = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      write_d      = write_q;
      cnt_d        = cnt_q;
      gnt_d        = '0;
      rsp_valid_d  = '0;
      rsp_err_d    = 1'b0;
      rsp_data_d   = '0;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_wsel_d   = mem_wsel_q;
      mem_rsel_d   = mem_rsel_q;
      mem_lsel_d   = mem_lsel_q;
      mem_addr_d   = mem_addr_q;
      mem_din_d    = mem_din_q;

      case (state_q)
         S_IDLE: begin
            if (|reqValid) begin
               gnt_d        = win_id ? 2'b10 : 2'b01;
               last_grant_d = win_id;
               id_d         = win_id;
               write_d      = sel_write;
               if (dec_err) begin
                  state_d = S_ERRRSP;
               end else begin
                  state_d    = S_ACCESS;
                  mem_addr_d = sel_addr;
                  mem_lsel_d = sel_f3;
                  mem_din_d  = sel_wdata << {off, 3'b000};
                  if (sel_write) begin
                     mem_we_d   = 1'b1;
                     mem_wsel_d = dec_sel;
                  end else begin
                     mem_re_d   = 1'b1;
                     mem_rsel_d = dec_sel;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (write_q) begin
               rsp_valid_d = id_q ? 2'b10 : 2'b01;
               state_d     = S_IDLE;
            end else begin
               cnt_d   = LAT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) begin
               rsp_valid_d = id_q ? 2'b10 : 2'b01;
               rsp_data_d  = memDataOut;
               state_d     = S_IDLE;
            end
         end
         default: begin
            rsp_valid_d = id_q ? 2'b10 : 2'b01;
            rsp_err_d   = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         write_q      <= 1'b0;
         cnt_q        <= '0;
         gnt_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_err_q    <= 1'b0;
         rsp_data_q   <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_wsel_q   <= '0;
         mem_rsel_q   <= '0;
         mem_lsel_q   <= '0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         write_q      <= write_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_data_q   <= rsp_data_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_wsel_q   <= mem_wsel_d;
         mem_rsel_q   <= mem_rsel_d;
         mem_lsel_q   <= mem_lsel_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
      end
   end

   assign reqGnt             = gnt_q;
   assign rspValid           = rsp_valid_q;
   assign rspErr             = rsp_err_q;
   assign rspData            = rsp_data_q;
   assign memReadEnable      = mem_re_q;
   assign memWriteEnable     = mem_we_q;
   assign memWriteByteSelect = mem_wsel_q;
   assign memReadByteSelect  = mem_rsel_q;
   assign memLoadSelect      = mem_lsel_q;
   assign memAddress         = mem_addr_q;
   assign memDataIn          = mem_din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (READ_LAT 1 and 3) sharing one stimulus set,
// a byte-lane memory model, and a reference model of the access rules.
module tb_dmem_arbiter;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam longint      LO   = 64'h8000_0000;
   localparam longint      HI   = LO + 4 * 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  reqValid = '0;
   logic [1:0]  reqWrite = '0;
   logic [5:0]  reqFunct3 = '0;
   logic [63:0] reqAddr = '0;
   logic [63:0] reqWdata = '0;
   logic        use3 = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   logic [1:0]  v1, v3, gnt1, gnt3, rv1, rv3;
   logic        err1, err3, re1, re3, we1, we3;
   logic [3:0]  ws1, ws3, rs1, rs3;
   logic [2:0]  ls1, ls3;
   logic [31:0] rd1, rd3, ma1, ma3, md1, md3, mo1, mo3;

   assign v1 = use3 ? 2'b00 : reqValid;
   assign v3 = use3 ? reqValid : 2'b00;

   dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .READ_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .reqValid(v1), .reqWrite(reqWrite), .reqFunct3(reqFunct3),
      .reqAddr(reqAddr), .reqWdata(reqWdata), .reqGnt(gnt1), .rspValid(rv1), .rspErr(err1),
      .rspData(rd1), .memReadEnable(re1), .memWriteEnable(we1), .memWriteByteSelect(ws1),
      .memReadByteSelect(rs1), .memLoadSelect(ls1), .memAddress(ma1), .memDataIn(md1),
      .memDataOut(mo1));

   dmem_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .READ_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .reqValid(v3), .reqWrite(reqWrite), .reqFunct3(reqFunct3),
      .reqAddr(reqAddr), .reqWdata(reqWdata), .reqGnt(gnt3), .rspValid(rv3), .rspErr(err3),
      .rspData(rd3), .memReadEnable(re3), .memWriteEnable(we3), .memWriteByteSelect(ws3),
      .memReadByteSelect(rs3), .memLoadSelect(ls3), .memAddress(ma3), .memDataIn(md3),
      .memDataOut(mo3));

   logic [1:0]  gnt, rspValid;
   logic        rspErr, re, we;
   logic [3:0]  wsel, rsel;
   logic [2:0]  lsel;
   logic [31:0] rspData, maddr, din;
   assign gnt      = use3 ? gnt3 : gnt1;
   assign rspValid = use3 ? rv3 : rv1;
   assign rspErr   = use3 ? err3 : err1;
   assign rspData  = use3 ? rd3 : rd1;
   assign re       = use3 ? re3 : re1;
   assign we       = use3 ? we3 : we1;
   assign wsel     = use3 ? ws3 : ws1;
   assign rsel     = use3 ? rs3 : rs1;
   assign lsel     = use3 ? ls3 : ls1;
   assign maddr    = use3 ? ma3 : ma1;
   assign din      = use3 ? md3 : md1;

   // memory model: byte-lane writes, read data valid only READ_LAT cycles after enable
   logic [31:0] mem [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        p1v = 1'b0;
   logic [31:0] p1d = '0;
   logic [2:0]  p3v = '0;
   logic [31:0] p3d0 = '0, p3d1 = '0, p3d2 = '0;

   function automatic logic [9:0] widx(input logic [31:0] a);
      return 10'((a - BASE) >> 2);
   endfunction

   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we1 && ws1[b]) mem[widx(ma1)][8*b +: 8] <= md1[8*b +: 8];
         if (we3 && ws3[b]) mem[widx(ma3)][8*b +: 8] <= md3[8*b +: 8];
      end
      p1v  <= re1;
      p1d  <= mem[widx(ma1)];
      p3v  <= {p3v[1:0], re3};
      p3d0 <= mem[widx(ma3)];
      p3d1 <= p3d0;
      p3d2 <= p3d1;
   end
   assign mo1 = p1v ? p1d : 32'hBAD0_BAD0;
   assign mo3 = p3v[2] ? p3d2 : 32'hBAD0_BAD0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, 32'({gnt, rspValid, rspErr, re, we, wsel, rsel, lsel}), 32'd0);
      check({tag, "_addr"}, maddr, 32'd0);
      check({tag, "_din"}, din, 32'd0);
      check({tag, "_rdata"}, rspData, 32'd0);
   endtask

   // reference rules: access size from funct3, natural alignment, legal range
   function automatic void predict(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                   output logic err, output logic [3:0] sel);
      int unsigned size;
      longint la;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      la  = longint'({32'd0, a});
      err = (size == 0) || (wr && f3[2]) || (la < LO) || (la >= HI);
      if (size != 0 && (a % size) != 0) err = 1'b1;
      sel = (size == 0) ? 4'd0 : 4'(((32'd1 << size) - 32'd1) << a[1:0]);
   endfunction

   task automatic do_txn(input int p, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      logic        err;
      logic [3:0]  sel;
      logic [31:0] exp_din, exp_data;
      int          n, lat, en_hi, exp_lat;
      predict(wr, f3, a, err, sel);
      exp_din = wd << (8 * a[1:0]);
      @(negedge clk);
      reqValid = '0;
      reqValid[p] = 1'b1;
      reqWrite[p] = wr;
      reqFunct3[3*p +: 3] = f3;
      reqAddr[32*p +: 32] = a;
      reqWdata[32*p +: 32] = wd;
      n = 0;
      do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
      reqValid = '0;
      check("gnt", 32'(gnt), (p == 1) ? 32'd2 : 32'd1);
      check("gnt_lat", 32'(n), 32'd1);
      if (!err) begin
         check("we", 32'(we), 32'(wr));
         check("re", 32'(re), 32'(!wr));
         check("addr", maddr, a);
         check("lsel", 32'(lsel), 32'(f3));
         if (wr) begin
            check("wsel", 32'(wsel), 32'(sel));
            check("din", din, exp_din);
         end else begin
            check("rsel", 32'(rsel), 32'(sel));
         end
      end else begin
         check("err_no_en", 32'({re, we}), 32'd0);
      end
      exp_data = (err || wr) ? 32'd0 : ref_mem[widx(a)];
      lat = 0;
      en_hi = 0;
      do begin
         @(negedge clk);
         lat++;
         if (re || we) en_hi++;
      end while (rspValid == 2'b00 && lat < 20);
      exp_lat = (err || wr) ? 1 : (use3 ? 4 : 2);
      check("rsp_lat", 32'(lat), 32'(exp_lat));
      check("rsp_id", 32'(rspValid), (p == 1) ? 32'd2 : 32'd1);
      check("rsp_err", 32'(rspErr), 32'(err));
      check("rsp_data", rspData, exp_data);
      check("en_once", 32'(en_hi), 32'd0);
      if (!err && wr) begin
         for (int b = 0; b < 4; b++)
            if (sel[b]) ref_mem[widx(a)][8*b +: 8] = exp_din[8*b +: 8];
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  exp_g;
      logic [2:0]  f3tab [0:9];
      int          g, cyc, seen;
      f3tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7, 3'd2, 3'd2};
      for (int i = 0; i < 1024; i++) begin
         mem[i] = '0;
         ref_mem[i] = '0;
      end

      repeat (2) @(negedge clk);
      check_zero("rst1");
      use3 = 1'b1;
      #1 check_zero("rst3");
      use3 = 1'b0;
      rst_n = 1'b1;

      // both ports requesting continuously from reset: strict alternation
      reqWrite = 2'b11;
      reqFunct3 = {3'd2, 3'd2};
      reqAddr = {BASE + 32'h200, BASE + 32'h100};
      reqWdata = {32'h2222_2222, 32'h1111_1111};
      reqValid = 2'b11;
      exp_g = 2'b01;
      g = 0;
      cyc = 0;
      while (g < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (gnt != 2'b00) begin
            check("rr_gnt", 32'(gnt), 32'(exp_g));
            exp_g = ~exp_g;
            g++;
         end
      end
      reqValid = '0;
      check("rr_count", 32'(g), 32'd4);
      repeat (3) @(negedge clk);
      ref_mem[64] = 32'h1111_1111;
      ref_mem[128] = 32'h2222_2222;

      do_txn(0, 1'b1, 3'd2, BASE + 32'h4, 32'hA5A5_A5A5);
      do_txn(0, 1'b0, 3'd2, BASE + 32'h4, 32'h0);
      do_txn(1, 1'b1, 3'd1, BASE + 32'hA, 32'h0000_BEEF);
      do_txn(1, 1'b0, 3'd5, BASE + 32'hA, 32'h0);
      do_txn(0, 1'b0, 3'd2, BASE + 32'h2, 32'h0);
      do_txn(0, 1'b0, 3'd0, 32'h7FFF_FFFF, 32'h0);
      do_txn(0, 1'b1, 3'd2, BASE + 32'h1000, 32'h1);
      do_txn(1, 1'b0, 3'd2, BASE + 32'hFFC, 32'h0);
      do_txn(1, 1'b0, 3'd2, 32'hFFFF_FFFC, 32'h0);
      do_txn(0, 1'b0, 3'd3, BASE + 32'h8, 32'h0);
      do_txn(1, 1'b1, 3'd4, BASE + 32'h8, 32'h5A);
      do_txn(0, 1'b1, 3'd0, BASE + 32'h13, 32'h0000_00C3);
      do_txn(0, 1'b0, 3'd4, BASE + 32'h13, 32'h0);

      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) a = $urandom;
         else a = BASE + $urandom_range(0, 255);
         do_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                f3tab[$urandom_range(0, 9)], a, $urandom);
      end

      // READ_LAT=3 instance
      use3 = 1'b1;
      do_txn(0, 1'b1, 3'd2, BASE + 32'h40, 32'h1234_5678);
      do_txn(0, 1'b0, 3'd2, BASE + 32'h40, 32'h0);
      do_txn(1, 1'b0, 3'd1, BASE + 32'h42, 32'h0);
      use3 = 1'b0;

      // reset while a load waits for data; port 0 was last granted beforehand
      @(negedge clk);
      reqWrite = '0;
      reqFunct3 = {3'd2, 3'd2};
      reqAddr = {BASE + 32'h4, BASE + 32'h4};
      reqValid = 2'b01;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (gnt == 2'b00 && cyc < 20);
      reqValid = '0;
      check("wait_gnt", 32'(gnt), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("rst_wait");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (rspValid != 2'b00) seen++;
      end
      check("no_rsp_after_rst", 32'(seen), 32'd0);
      reqValid = 2'b11;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (gnt == 2'b00 && cyc < 20);
      reqValid = '0;
      check("post_rst_gnt", 32'(gnt), 32'd1);
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
